// File: rtl/spatz_cache_bank_initiator_if.sv
// Cache-controller side of the bank initiator: request stream in, response stream out.
// master = cache controller, slave = bank initiator.
interface spatz_cache_bank_initiator_if #(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 4,
    parameter int unsigned IdWidth   = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [AddrWidth-1:0] req_addr;
    logic [DataWidth-1:0] req_wdata;
    logic [ByteWidth-1:0] req_be;
    logic [IdWidth-1:0]   req_id;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DataWidth-1:0] rsp_rdata;
    logic [IdWidth-1:0]   rsp_id;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, req_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, req_id, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_id, rsp_err
    );
endinterface

// File: rtl/spatz_cache_bank_initiator.sv
// Requester-side adapter for one cache port of the hybrid SPM/cache bank: credit-limited
// issue, fixed-latency read capture, in-order response buffering, local SPM-region rejection.

module spatz_cache_bank_initiator_chk (
    input logic clk_i,
    input logic rst_i,
    input logic push_i,
    input logic full_i
);
    // Credits cap outstanding requests at the buffer depth, so a push never meets a full buffer.
    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_i))
        else $error("response buffer overflow");
endmodule

module spatz_cache_bank_initiator #(
    parameter int unsigned BankAddrWidth         = 8,
    parameter int unsigned DataWidth             = 32,
    parameter int unsigned ByteWidth             = 4,
    parameter int unsigned IdWidth               = 4,
    parameter int unsigned MemoryResponseLatency = 1,
    parameter int unsigned RspFifoDepth          = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [BankAddrWidth-1:0] spm_size_i,
    spatz_cache_bank_initiator_if.slave ctrl,
    output logic                     bank_req_o,
    output logic                     bank_we_o,
    output logic [BankAddrWidth-1:0] bank_addr_o,
    output logic [DataWidth-1:0]     bank_wdata_o,
    output logic [ByteWidth-1:0]     bank_be_o,
    input  logic                     bank_ready_i,
    input  logic [DataWidth-1:0]     bank_rdata_i,
    output logic                     busy_o
);
    localparam int unsigned CntW = $clog2(RspFifoDepth + 1);
    localparam int unsigned PtrW = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam int unsigned Last = MemoryResponseLatency - 1;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspFifoDepth - 1)) ? {PtrW{1'b0}} : p + PtrW'(1);
    endfunction

    logic illegal_s, credit_ok_s, accept_s, push_s, pop_s, full_s, empty_s;
    logic [DataWidth-1:0] push_rdata_s;
    logic [CntW-1:0]      count_q, count_d, fcnt_q, fcnt_d;
    logic                 busy_q;

    logic [MemoryResponseLatency-1:0] pipe_vld_q, pipe_we_q, pipe_err_q;
    logic [IdWidth-1:0]               pipe_id_q [MemoryResponseLatency];

    logic [DataWidth-1:0] mem_rdata_q [RspFifoDepth];
    logic [IdWidth-1:0]   mem_id_q    [RspFifoDepth];
    logic                 mem_err_q   [RspFifoDepth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;

    assign illegal_s   = ctrl.req_addr < spm_size_i;
    assign credit_ok_s = count_q < CntW'(RspFifoDepth);
    assign accept_s    = ctrl.req_valid & ctrl.req_ready;

    assign ctrl.req_ready = credit_ok_s & (illegal_s | bank_ready_i) & ~rst_i;
    assign bank_req_o     = ctrl.req_valid & ~illegal_s & credit_ok_s & ~rst_i;
    assign bank_we_o      = ctrl.req_we;
    assign bank_addr_o    = ctrl.req_addr;
    assign bank_wdata_o   = ctrl.req_wdata;
    assign bank_be_o      = ctrl.req_be;

    // Bank data is only meaningful for legal reads; writes and rejected accesses answer zero.
    assign push_s       = pipe_vld_q[Last];
    assign push_rdata_s = (!pipe_we_q[Last] && !pipe_err_q[Last]) ? bank_rdata_i : {DataWidth{1'b0}};

    assign full_s         = fcnt_q == CntW'(RspFifoDepth);
    assign empty_s        = fcnt_q == CntW'(0);
    assign pop_s          = ~empty_s & ctrl.rsp_ready;
    assign ctrl.rsp_valid = ~empty_s;
    assign ctrl.rsp_rdata = mem_rdata_q[rd_ptr_q];
    assign ctrl.rsp_id    = mem_id_q[rd_ptr_q];
    assign ctrl.rsp_err   = mem_err_q[rd_ptr_q];
    assign busy_o         = busy_q;

    // Outstanding-credit and buffer-occupancy next state.
    always_comb begin
        count_d = count_q;
        fcnt_d  = fcnt_q;
        if (accept_s && !pop_s) begin
            count_d = count_q + CntW'(1);
        end else if (!accept_s && pop_s) begin
            count_d = count_q - CntW'(1);
        end else begin
            count_d = count_q;
        end
        if (push_s && !pop_s) begin
            fcnt_d = fcnt_q + CntW'(1);
        end else if (!push_s && pop_s) begin
            fcnt_d = fcnt_q - CntW'(1);
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // Latency pipeline; reset flushes in-flight requests so late bank data is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
            pipe_we_q  <= '0;
            pipe_err_q <= '0;
            for (int i = 0; i < int'(MemoryResponseLatency); i++) pipe_id_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= accept_s;
            pipe_we_q[0]  <= ctrl.req_we;
            pipe_err_q[0] <= illegal_s;
            pipe_id_q[0]  <= ctrl.req_id;
            for (int i = 1; i < int'(MemoryResponseLatency); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_we_q[i]  <= pipe_we_q[i-1];
                pipe_err_q[i] <= pipe_err_q[i-1];
                pipe_id_q[i]  <= pipe_id_q[i-1];
            end
        end
    end

    // Counters, pointers and busy flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            fcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= count_d != CntW'(0);
            if (push_s) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_s)  rd_ptr_q <= next_ptr(rd_ptr_q);
        end
    end

    // Response storage; validity is tracked by the occupancy count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_rdata_q[wr_ptr_q] <= push_rdata_s;
            mem_id_q[wr_ptr_q]    <= pipe_id_q[Last];
            mem_err_q[wr_ptr_q]   <= pipe_err_q[Last];
        end
    end

    spatz_cache_bank_initiator_chk u_chk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push_s),
        .full_i (full_s)
    );
endmodule

// File: tb/tb_spatz_cache_bank_initiator.sv
// Directed self-checking bench: latency=1, response depth 2, SPM boundary at address 4.
module tb_spatz_cache_bank_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  spm_size;
    logic        bank_req, bank_we, bank_ready, busy;
    logic [7:0]  bank_addr;
    logic [31:0] bank_wdata, bank_rdata;
    logic [3:0]  bank_be;
    int          checks = 0;
    int          failures = 0;

    spatz_cache_bank_initiator_if #(.AddrWidth(8), .DataWidth(32), .ByteWidth(4), .IdWidth(4)) cif ();

    spatz_cache_bank_initiator #(
        .BankAddrWidth(8), .DataWidth(32), .ByteWidth(4), .IdWidth(4),
        .MemoryResponseLatency(1), .RspFifoDepth(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spm_size_i   (spm_size),
        .ctrl         (cif),
        .bank_req_o   (bank_req),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_wdata_o (bank_wdata),
        .bank_be_o    (bank_be),
        .bank_ready_i (bank_ready),
        .bank_rdata_i (bank_rdata),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] rdata, input logic [3:0] id, input logic err);
        chk({tag, "_valid"}, {31'd0, cif.rsp_valid}, 32'd1);
        chk({tag, "_rdata"}, cif.rsp_rdata, rdata);
        chk({tag, "_id"}, {28'd0, cif.rsp_id}, {28'd0, id});
        chk({tag, "_err"}, {31'd0, cif.rsp_err}, {31'd0, err});
    endtask

    task automatic drive_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] id);
        cif.req_valid = 1'b1;
        cif.req_we    = we;
        cif.req_addr  = addr;
        cif.req_wdata = wdata;
        cif.req_be    = 4'hF;
        cif.req_id    = id;
    endtask

    initial begin
        rst = 1'b1; spm_size = 8'd4; bank_ready = 1'b1; bank_rdata = 32'd0;
        cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_addr = 8'd0;
        cif.req_wdata = 32'd0; cif.req_be = 4'd0; cif.req_id = 4'd0; cif.rsp_ready = 1'b0;
        tick();
        drive_req(1'b0, 8'h10, 32'd0, 4'd3);
        #1;
        chk("rst_req_ready", {31'd0, cif.req_ready}, 32'd0);
        chk("rst_bank_req", {31'd0, bank_req}, 32'd0);
        tick();
        chk("rst_rsp_valid", {31'd0, cif.rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Basic read: accept in t, data in t+1, response in t+2.
        rst = 1'b0;
        #1;
        chk("rd_bank_req", {31'd0, bank_req}, 32'd1);
        chk("rd_req_ready", {31'd0, cif.req_ready}, 32'd1);
        tick();
        cif.req_valid = 1'b0; bank_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_t1_rsp_valid", {31'd0, cif.rsp_valid}, 32'd0);
        chk("rd_t1_busy", {31'd0, busy}, 32'd1);
        tick();
        bank_rdata = 32'h12345678;
        chk_rsp("rd_rsp", 32'hDEADBEEF, 4'd3, 1'b0);
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
        #1;
        chk("rd_done_valid", {31'd0, cif.rsp_valid}, 32'd0);
        chk("rd_done_busy", {31'd0, busy}, 32'd0);

        // Stalled write held on the bank port for three cycles.
        bank_ready = 1'b0;
        drive_req(1'b1, 8'h20, 32'hCAFEF00D, 4'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req_ready", {31'd0, cif.req_ready}, 32'd0);
            chk("stall_bank_req", {31'd0, bank_req}, 32'd1);
            chk("stall_bank_addr", {24'd0, bank_addr}, 32'h20);
            chk("stall_bank_wdata", bank_wdata, 32'hCAFEF00D);
            chk("stall_bank_we", {31'd0, bank_we}, 32'd1);
            tick();
        end
        bank_ready = 1'b1;
        #1;
        chk("stall_accept_ready", {31'd0, cif.req_ready}, 32'd1);
        tick();
        cif.req_valid = 1'b0; bank_rdata = 32'hFFFFFFFF;
        tick();
        chk_rsp("wr_rsp", 32'd0, 4'd5, 1'b0);
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
        #1;
        chk("wr_done_valid", {31'd0, cif.rsp_valid}, 32'd0);

        // Illegal access behind a legal one, accepted locally even with the bank busy.
        drive_req(1'b0, 8'h08, 32'd0, 4'd1);
        #1;
        chk("ill_legal_bank_req", {31'd0, bank_req}, 32'd1);
        tick();
        drive_req(1'b0, 8'h02, 32'd0, 4'd2);
        bank_ready = 1'b0; bank_rdata = 32'hA5A50008;
        #1;
        chk("ill_bank_req", {31'd0, bank_req}, 32'd0);
        chk("ill_req_ready", {31'd0, cif.req_ready}, 32'd1);
        tick();
        cif.req_valid = 1'b0; bank_ready = 1'b1; bank_rdata = 32'h77777777;
        #1;
        chk_rsp("ill_rsp0", 32'hA5A50008, 4'd1, 1'b0);
        cif.rsp_ready = 1'b1;
        tick();
        chk_rsp("ill_rsp1", 32'd0, 4'd2, 1'b1);
        tick();
        cif.rsp_ready = 1'b0;
        #1;
        chk("ill_done_valid", {31'd0, cif.rsp_valid}, 32'd0);
        chk("ill_done_busy", {31'd0, busy}, 32'd0);

        // Credit limit at depth 2 with responses back-pressured.
        drive_req(1'b0, 8'h30, 32'd0, 4'd6);
        #1;
        chk("cred_a_ready", {31'd0, cif.req_ready}, 32'd1);
        tick();
        drive_req(1'b0, 8'h31, 32'd0, 4'd7);
        bank_rdata = 32'h11110030;
        #1;
        chk("cred_b_ready", {31'd0, cif.req_ready}, 32'd1);
        tick();
        drive_req(1'b0, 8'h32, 32'd0, 4'd8);
        bank_rdata = 32'h11110031;
        #1;
        chk("cred_c_ready", {31'd0, cif.req_ready}, 32'd0);
        chk("cred_c_bank_req", {31'd0, bank_req}, 32'd0);
        tick();
        bank_rdata = 32'h0;
        chk("cred_d_ready", {31'd0, cif.req_ready}, 32'd0);
        chk_rsp("cred_rsp6", 32'h11110030, 4'd6, 1'b0);
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
        #1;
        chk("cred_e_ready", {31'd0, cif.req_ready}, 32'd1);
        chk_rsp("cred_rsp7", 32'h11110031, 4'd7, 1'b0);
        tick();
        cif.req_valid = 1'b0; bank_rdata = 32'h11110032; cif.rsp_ready = 1'b1;
        tick();
        chk_rsp("cred_rsp8", 32'h11110032, 4'd8, 1'b0);
        tick();
        cif.rsp_ready = 1'b0;
        #1;
        chk("cred_done_valid", {31'd0, cif.rsp_valid}, 32'd0);
        chk("cred_done_busy", {31'd0, busy}, 32'd0);

        // Accept and response handshake in the same cycle with one outstanding.
        drive_req(1'b0, 8'h40, 32'd0, 4'd9);
        tick();
        cif.req_valid = 1'b0; bank_rdata = 32'h40404040;
        tick();
        drive_req(1'b0, 8'h41, 32'd0, 4'd10);
        cif.rsp_ready = 1'b1;
        #1;
        chk("sim_req_ready", {31'd0, cif.req_ready}, 32'd1);
        chk_rsp("sim_rsp9", 32'h40404040, 4'd9, 1'b0);
        tick();
        cif.req_valid = 1'b0; cif.rsp_ready = 1'b0; bank_rdata = 32'h41414141;
        #1;
        chk("sim_busy", {31'd0, busy}, 32'd1);
        chk("sim_gap_valid", {31'd0, cif.rsp_valid}, 32'd0);
        tick();
        chk_rsp("sim_rsp10", 32'h41414141, 4'd10, 1'b0);
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
        #1;
        chk("sim_done_valid", {31'd0, cif.rsp_valid}, 32'd0);
        chk("sim_done_busy", {31'd0, busy}, 32'd0);

        // Reset right after an accept drops the request entirely.
        drive_req(1'b0, 8'h50, 32'd0, 4'd11);
        tick();
        cif.req_valid = 1'b0; rst = 1'b1; bank_rdata = 32'h50505050;
        tick();
        rst = 1'b0; bank_rdata = 32'h51515151; cif.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_mid_valid", {31'd0, cif.rsp_valid}, 32'd0);
            chk("rst_mid_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        cif.rsp_ready = 1'b0;

        // SPM boundary: address equal to spm_size is legal, one below is not.
        drive_req(1'b0, 8'h04, 32'd0, 4'd0);
        #1;
        chk("bnd_eq_bank_req", {31'd0, bank_req}, 32'd1);
        cif.req_addr = 8'h03;
        #1;
        chk("bnd_lt_bank_req", {31'd0, bank_req}, 32'd0);
        cif.req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spatz_cache_bank_initiator.md
Name: spatz_cache_bank_initiator

Overview:
- Requester-side adapter that drives one cache port of the hybrid SPM/cache SRAM bank.
- Turns a valid/ready request stream from the cache controller into the bank port protocol: request held until the bank grants it, read data returned at a fixed latency that cannot be stalled.
- Buffers responses, limits outstanding requests with credits, and rejects accesses into the SPM region locally.
- One instance per bank, between the cache controller and the SRAM wrapper.

Parameters:
- BankAddrWidth, 8, bank word-address width.
- DataWidth, 32, data width.
- ByteWidth, 4, byte-enable width.
- IdWidth, 4, transaction ID width.
- MemoryResponseLatency, 1, bank read latency in cycles, 1 or more; must match the wrapper.
- RspFifoDepth, 4, response buffer entries and maximum outstanding requests; 2 or more.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- spm_size_i  in  BankAddrWidth  bank addresses below this value belong to the SPM.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle when valid is also high.
- req_we_i  in  1  write enable.
- req_addr_i  in  BankAddrWidth  bank word address.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  ByteWidth  byte enables.
- req_id_i  in  IdWidth  transaction ID.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  DataWidth  read data; 0 for writes and errors.
- rsp_id_o  out  IdWidth  ID of the request being answered.
- rsp_err_o  out  1  request addressed the SPM region.
- bank_req_o, bank_we_o  out  1  bank port request and write enable.
- bank_addr_o  out  BankAddrWidth  bank port address.
- bank_wdata_o  out  DataWidth  bank port write data.
- bank_be_o  out  ByteWidth  bank port byte enables.
- bank_ready_i  in  1  bank grant; 0 while the SPM holds the bank.
- bank_rdata_i  in  DataWidth  bank read data, valid MemoryResponseLatency cycles after grant.
- busy_o  out  1  outstanding count is nonzero.

Behaviour:
- Reset values: rsp_valid_o=0, bank_req_o=0, req_ready_o=0, busy_o=0; response FIFO empty; latency pipeline cleared; credit count 0.
- Definitions:
  - illegal = req_addr_i < spm_size_i (unsigned compare).
  - credit_ok = count < RspFifoDepth.
- Bank drive:
  - bank_req_o = req_valid_i & ~illegal & credit_ok & ~rst_i.
  - bank_we_o, bank_addr_o, bank_wdata_o and bank_be_o pass through combinationally.
- Acceptance:
  - req_ready_o = credit_ok & (illegal | bank_ready_i).
  - Accept = req_valid_i & req_ready_o.
  - An illegal request never reaches the bank; it is accepted locally.
- Stall: while bank_ready_i=0, a legal request stays presented on the bank port; the upstream must hold it stable (valid/ready rule).
- Latency pipeline:
  - MemoryResponseLatency stages, each carrying {valid, we, err, id}.
  - Stage 0 loads on accept.
  - At the last stage, {id, err, rdata} is pushed into the FIFO. rdata = bank_rdata_i for a legal read, 0 otherwise.
  - Push occurs in cycle t+L, where t is the accept cycle and L is MemoryResponseLatency.
  - Earliest rsp_valid_o is cycle t+L+1.
- Ordering: every accepted request, read, write or illegal, produces exactly one response, strictly in acceptance order.
- Response FIFO: standard first-word-through output; the output holds stable while rsp_valid_o=1 and rsp_ready_i=0.
- Credit count (0..RspFifoDepth):
  - +1 on accept, -1 on response handshake, unchanged when both occur in the same cycle.
  - Because accepts are capped by credits, the FIFO can never overflow. Reaching a push with the FIFO full is an assertion failure.
- busy_o = (count != 0), registered from the count.
- Reset mid-operation: in-flight pipeline entries and FIFO contents are discarded; bank data arriving after reset is ignored; no responses are produced for dropped requests.
- spm_size_i may change at any time; it is sampled only in the accept cycle.

Test Plan:
- L=1, spm_size=4: read addr 0x10 accepted in cycle t, bank_rdata=0xDEADBEEF in t+1 -> rsp_valid in t+2 with rdata 0xDEADBEEF, id=3, err=0; busy_o falls after the handshake.
- Stall: bank_ready_i=0 for 3 cycles with a write pending -> req_ready_o=0 and bank_req_o held with stable addr/data; accepted in cycle 4; one response with rdata 0.
- Illegal: spm_size=4, read addr 2 issued behind a legal read of addr 8 -> bank_req_o never asserted for addr 2; responses in order: (addr 8 data, err=0), then (rdata 0, err=1).
- Credit limit: depth=2, rsp_ready_i=0, three back-to-back reads -> third sees req_ready_o=0; one rsp handshake -> third accepted next cycle.
- Simultaneous events: count=1, accept and rsp handshake in the same cycle -> count stays 1; no response lost or duplicated.
- Reset: read accepted in t, rst_i high in t+1 -> no response ever appears; count=0, busy_o=0, rsp_valid_o=0 after reset.
